// File: rtl/rr_arb_pkg.sv
// Shared constants for the round-robin request frontend.
//   RR_N     : default number of requesting channels
//   RR_W     : default payload width
//   RR_DEPTH : default per-channel queue depth (power of 2)
//   RR_ID_W  : width of a channel index for the default RR_N
package rr_arb_pkg;
   localparam int RR_N     = 4;
   localparam int RR_W     = 8;
   localparam int RR_DEPTH = 4;
   localparam int RR_ID_W  = $clog2(RR_N);
endpackage

// File: rtl/rr_req_fifo.sv
// Per-channel synchronous FIFO with occupancy count.
//   clk, rst_n : clock, async active-low reset (pointers and count cleared)
//   push       : write wr_data (caller guarantees !full)
//   pop        : drop head entry (caller guarantees !empty)
//   rd_data    : current head entry
//   count      : occupancy, 0..DEPTH
//   full/empty : occupancy flags
module rr_req_fifo
   import rr_arb_pkg::*;
#(
   parameter int W     = RR_W,
   parameter int DEPTH = RR_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               wr_data,
   output logic [W-1:0]               rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   // DEPTH is a power of 2, so pointer overflow is the modulo wrap.
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: contents are only visible through count.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;
   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
endmodule

// File: rtl/rr_req_frontend.sv
// Request frontend for an external round-robin arbiter.
// Each channel buffers producer payloads in its own FIFO and raises req
// while non-empty and the output register can take a payload. The arbiter
// answers with a combinational grant; a legal grant pops the channel head
// into the output register at the same edge.
//   clk, rst_n      : clock, async active-low reset
//   in_valid/in_data/in_ready : per-channel producer handshake (N x W data)
//   req/grant       : arbiter request/grant vectors
//   out_valid/out_data/out_id/out_ready : registered consumer handshake
//   err_grant       : one-cycle pulse after an illegal grant
module rr_req_frontend
   import rr_arb_pkg::*;
#(
   parameter int N     = RR_N,
   parameter int W     = RR_W,
   parameter int DEPTH = RR_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N-1:0]          in_valid,
   input  logic [N*W-1:0]        in_data,
   output logic [N-1:0]          in_ready,
   output logic [N-1:0]          req,
   input  logic [N-1:0]          grant,
   output logic                  out_valid,
   output logic [W-1:0]          out_data,
   output logic [$clog2(N)-1:0]  out_id,
   input  logic                  out_ready,
   output logic                  err_grant
);
   localparam int IW = $clog2(N);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [N-1:0]  fifo_full, fifo_empty, push, pop;
   logic [W-1:0]  head [N];
   logic [CW-1:0] fifo_count [N];

   logic          accept, grant_legal;
   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  out_data_q,  out_data_d;
   logic [IW-1:0] out_id_q,    out_id_d;
   logic          err_grant_q, err_grant_d;

   for (genvar g = 0; g < N; g++) begin : g_ch
      rr_req_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
         .clk     (clk),
         .rst_n   (rst_n),
         .push    (push[g]),
         .pop     (pop[g]),
         .wr_data (in_data[g*W +: W]),
         .rd_data (head[g]),
         .count   (fifo_count[g]),
         .full    (fifo_full[g]),
         .empty   (fifo_empty[g])
      );

      a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
         fifo_count[g] <= CW'(DEPTH));
   end

   assign accept   = !out_valid_q || out_ready;
   assign req      = ~fifo_empty & {N{accept}};
   assign in_ready = ~fifo_full;
   assign push     = in_valid & in_ready;

   // With accept low req is all zero, so any grant then fails the subset test.
   assign grant_legal = $onehot(grant) && ((grant & ~req) == '0);
   assign pop         = grant_legal ? grant : '0;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      err_grant_d = (grant != '0) && !grant_legal;
      if (grant_legal) begin
         out_valid_d = 1'b1;
         for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
               out_data_d = head[i];
               out_id_d   = IW'(i);
            end
         end
      end else if (accept) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         err_grant_q <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
         err_grant_q <= err_grant_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_id    = out_id_q;
   assign err_grant = err_grant_q;

   // A multi-hot grant is tolerated (dropped) but must always be flagged.
   a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
      !$onehot0(grant) |=> err_grant_q);
endmodule

// File: tb/tb_rr_req_frontend.sv
module tb_rr_req_frontend;
   logic        clk;
   logic        rst_n;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic [3:0]  in_ready;
   logic [3:0]  req;
   logic [3:0]  grant;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_id;
   logic        out_ready;
   logic        err_grant;

   logic [3:0]  grant_man;
   logic [3:0]  rr_grant;
   logic [1:0]  rr_ptr;
   logic        use_rr;
   logic        rr_clear;
   logic        mon_en;

   logic [9:0]  exp_q [$];
   int          n_checks;
   int          n_errors;
   int          n_cyc;

   rr_req_frontend #(.N(4), .W(8), .DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .req       (req),
      .grant     (grant),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_id    (out_id),
      .out_ready (out_ready),
      .err_grant (err_grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference round-robin arbiter: first requester at or after rr_ptr.
   always_comb begin
      rr_grant = '0;
      for (int k = 0; k < 4; k++) begin
         if (rr_grant == '0 && req[2'(rr_ptr + 2'(k))])
            rr_grant[2'(rr_ptr + 2'(k))] = 1'b1;
      end
   end

   always_comb grant = use_rr ? rr_grant : grant_man;

   always @(posedge clk) begin
      if (!rst_n || rr_clear) rr_ptr <= '0;
      else if (use_rr) begin
         for (int i = 0; i < 4; i++)
            if (grant[i]) rr_ptr <= 2'(i + 1);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, expv);
      end
   endtask

   // A transfer completes at the next rising edge; inputs are stable here.
   always @(negedge clk) begin
      if (mon_en && rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("sb_unexpected", 32'(out_data), 32'hFFFF);
         else begin
            logic [9:0] e;
            e = exp_q.pop_front();
            chk("sb_id", 32'(out_id), 32'(e[9:8]));
            chk("sb_data", 32'(out_data), 32'(e[7:0]));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int max_cyc, output int n);
      n = 0;
      while (exp_q.size() != 0 && n < max_cyc) begin
         cyc();
         n++;
      end
      chk("drain_left", 32'(exp_q.size()), 0);
   endtask

   task automatic set_data(input int ch, input logic [7:0] d);
      in_data[ch*8 +: 8] = d;
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b1;
      grant_man = '0; use_rr = 1'b0; rr_clear = 1'b0; mon_en = 1'b1;
      #2;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_id", 32'(out_id), 0);
      chk("rst_err", 32'(err_grant), 0);
      chk("rst_req", 32'(req), 0);
      chk("rst_in_ready", 32'(in_ready), 32'hF);
      #10 rst_n = 1'b1;
      cyc();

      // Single push on channel 2, granted next cycle.
      in_valid = 4'b0100; set_data(2, 8'hA1);
      cyc();
      in_valid = '0;
      chk("single_req", 32'(req), 32'b0100);
      grant_man = 4'b0100; exp_q.push_back({2'd2, 8'hA1});
      cyc();
      grant_man = '0;
      chk("single_valid", 32'(out_valid), 1);
      chk("single_data", 32'(out_data), 32'hA1);
      chk("single_id", 32'(out_id), 2);
      chk("single_empty", 32'(req), 0);
      cyc();
      chk("single_clear", 32'(out_valid), 0);

      // Fill channel 0 behind a stalled output register.
      out_ready = 1'b0;
      in_valid = 4'b1000; set_data(3, 8'h3F);
      cyc();
      in_valid = '0;
      grant_man = 4'b1000; exp_q.push_back({2'd3, 8'h3F});
      cyc();
      grant_man = '0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 4'b0001; set_data(0, 8'(8'h10 + k));
         exp_q.push_back({2'd0, 8'(8'h10 + k)});
         cyc();
      end
      chk("full_in_ready", 32'(in_ready[0]), 0);
      chk("stall_req", 32'(req), 0);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_data", 32'(out_data), 32'h3F);
      set_data(0, 8'hEE);
      cyc();
      in_valid = '0;
      chk("full_hold", 32'(in_ready[0]), 0);
      out_ready = 1'b1; use_rr = 1'b1;
      drain(20, n_cyc);
      use_rr = 1'b0;
      chk("fill_drained_valid", 32'(out_valid), 0);
      chk("fill_drained_ready", 32'(in_ready), 32'hF);

      // Simultaneous push and pop on channel 1 at count 2.
      for (int k = 0; k < 2; k++) begin
         in_valid = 4'b0010; set_data(1, 8'(8'h50 + k));
         cyc();
      end
      set_data(1, 8'h55); grant_man = 4'b0010;
      exp_q.push_back({2'd1, 8'h50});
      cyc();
      in_valid = '0; grant_man = '0;
      chk("pp_data", 32'(out_data), 32'h50);
      exp_q.push_back({2'd1, 8'h51});
      exp_q.push_back({2'd1, 8'h55});
      use_rr = 1'b1;
      drain(10, n_cyc);
      use_rr = 1'b0;
      chk("pp_empty_req", 32'(req), 0);

      // Illegal grants: multi-hot, and a bit outside req.
      in_valid = 4'b0011; set_data(0, 8'h60); set_data(1, 8'h61);
      cyc();
      in_valid = '0;
      chk("ill_req", 32'(req), 32'b0011);
      grant_man = 4'b0011;
      cyc();
      grant_man = '0;
      chk("ill_err", 32'(err_grant), 1);
      chk("ill_valid", 32'(out_valid), 0);
      chk("ill_nopop", 32'(req), 32'b0011);
      cyc();
      chk("ill_err_pulse", 32'(err_grant), 0);
      grant_man = 4'b0100;
      cyc();
      grant_man = '0;
      chk("ill_unreq_err", 32'(err_grant), 1);
      chk("ill_unreq_nopop", 32'(req), 32'b0011);
      rr_clear = 1'b1;
      cyc();
      rr_clear = 1'b0;
      chk("ill_err_gone", 32'(err_grant), 0);
      exp_q.push_back({2'd0, 8'h60});
      exp_q.push_back({2'd1, 8'h61});
      use_rr = 1'b1;
      drain(10, n_cyc);
      use_rr = 1'b0;

      // All channels loaded, round-robin, one payload per cycle.
      for (int k = 0; k < 3; k++) begin
         in_valid = 4'b1111;
         for (int c = 0; c < 4; c++) set_data(c, 8'(8'h80 + c*16 + k));
         cyc();
      end
      in_valid = '0;
      rr_clear = 1'b1;
      cyc();
      rr_clear = 1'b0;
      for (int k = 0; k < 3; k++)
         for (int c = 0; c < 4; c++)
            exp_q.push_back({2'(c), 8'(8'h80 + c*16 + k)});
      use_rr = 1'b1;
      drain(40, n_cyc);
      use_rr = 1'b0;
      chk("b2b_cycles", 32'(n_cyc), 13);

      // Asynchronous reset with queued and registered payloads.
      out_ready = 1'b0;
      in_valid = 4'b0101; set_data(0, 8'h90); set_data(2, 8'h22);
      cyc();
      in_valid = 4'b0001; set_data(0, 8'h91); grant_man = 4'b0100;
      cyc();
      grant_man = '0; set_data(0, 8'h92);
      cyc();
      in_valid = '0;
      chk("pre_rst_valid", 32'(out_valid), 1);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 0);
      chk("arst_req", 32'(req), 0);
      chk("arst_in_ready", 32'(in_ready), 32'hF);
      chk("arst_data", 32'(out_data), 0);
      exp_q.delete();
      #2 rst_n = 1'b1;
      in_valid = 4'b0010; set_data(1, 8'h77);
      cyc();
      in_valid = '0;
      chk("post_rst_req", 32'(req), 32'b0010);
      out_ready = 1'b1; grant_man = 4'b0010;
      exp_q.push_back({2'd1, 8'h77});
      cyc();
      grant_man = '0;
      chk("post_rst_data", 32'(out_data), 32'h77);
      chk("post_rst_id", 32'(out_id), 1);
      cyc();
      chk("final_sb_empty", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/rr_req_frontend.md
RR_REQ_FRONTEND -- requirements
Module: rr_req_frontend

Interface
REQ-001 Parameter N, 4, number of requesting channels (N >= 2).
REQ-002 Parameter W, 8, payload width in bits.
REQ-003 Parameter DEPTH, 4, per-channel queue depth (power of 2, >= 2).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  N  per-channel producer valid.
REQ-007 in_data  input  N x W  per-channel producer payload.
REQ-008 in_ready  output  N  per-channel queue not full.
REQ-009 req  output  N  request lines to the round-robin arbiter.
REQ-010 grant  input  N  grant from the arbiter, combinational from req in the same cycle.
REQ-011 out_valid  output  1  registered output holds a granted payload.
REQ-012 out_data  output  W  granted payload.
REQ-013 out_id  output  $clog2(N)  index of the channel that supplied out_data.
REQ-014 out_ready  input  1  downstream consumer accepts out_data.
REQ-015 err_grant  output  1  one-cycle pulse flagging an illegal grant.

Function
REQ-016 Each channel SHALL own a DEPTH-entry FIFO; push when in_valid[i] && in_ready[i]; in_ready[i] = (count[i] < DEPTH).
REQ-017 accept = !out_valid || out_ready, combinational.
REQ-018 req[i] SHALL equal (count[i] != 0) && accept, purely combinational, no registered delay.
REQ-019 A grant is legal when grant is one-hot and grant & ~req == 0.
REQ-020 On a legal grant[i]: at that clock edge pop channel i head; load out_data = head, out_id = i, out_valid = 1 (0-cycle arbitration, 1-cycle req-to-out_valid latency).
REQ-021 No grant (grant == 0) with accept: out_valid cleared at the edge if out_ready was high; out_data/out_id hold.
REQ-022 With !accept, req SHALL be all zero and out_valid/out_data/out_id SHALL hold.
REQ-023 Illegal grant (multi-hot, or any bit set where req low): no FIFO pops, treated as grant == 0, err_grant = 1 in the following cycle only.
REQ-024 Simultaneous push and pop on one channel SHALL be allowed; count unchanged; FIFO ordering preserved.
REQ-025 Push while full SHALL be impossible (in_ready low); in_valid with in_ready low SHALL leave the FIFO untouched.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; count width $clog2(DEPTH)+1, range 0..DEPTH.
REQ-027 Back-to-back transfers: with out_ready held high and grants every cycle, one payload per cycle SHALL be delivered.

Reset
REQ-028 On rst_n low, asynchronously: all FIFOs empty (counts and pointers 0), out_valid 0, out_data 0, out_id 0, err_grant 0; req therefore 0 and in_ready all 1.
REQ-029 Reset mid-operation SHALL discard all queued and registered payloads; the first push after release is accepted on the first rising edge with rst_n high.

Structure
REQ-030 A shared package rr_arb_pkg SHALL hold the default N, W and DEPTH constants and the id-width constant.
REQ-031 A single sub-module rr_req_fifo (synchronous FIFO with count, push/pop, full/empty) SHALL be instantiated N times.
REQ-032 An always-on assertion SHALL check $onehot0(grant) whenever rst_n is high, companion to err_grant.

Verification
REQ-033 Reset then push 0xA1 on channel 2, arbiter grants 4'b0100 -> next cycle out_valid=1, out_data=0xA1, out_id=2, count[2]=0.
REQ-034 Fill channel 0 with 4 pushes (0x10..0x13), out_ready=0 -> in_ready[0]=0 after fourth push, req=0 while out_valid held; release out_ready -> 0x10..0x13 delivered in order.
REQ-035 Drive grant=4'b0011 while req=4'b0011 -> no pops, out_valid unchanged, err_grant=1 for exactly one cycle.
REQ-036 All four channels loaded, connected to the round-robin arbiter, out_ready=1 -> out_id sequence 0,1,2,3,0,... one per cycle.
REQ-037 Channel 1 at count 2, simultaneous push 0x55 and grant 4'b0010 -> count[1] stays 2; 0x55 emerges after the older entry.
REQ-038 Assert rst_n low with 3 entries queued and out_valid=1 -> out_valid=0, req=0, in_ready=4'b1111 immediately, without waiting for a clock edge.
